// File: rtl/pcpi_muldiv_iter_if.sv
// PCPI handshake bundle between a picorv32 core (master) and a coprocessor (slave).
// Groups the instruction, operand and result signals of one PCPI port.
interface pcpi_muldiv_iter_if;
   logic        pcpi_valid;
   logic [31:0] pcpi_insn;
   logic [31:0] pcpi_rs1;
   logic [31:0] pcpi_rs2;
   logic        pcpi_wr;
   logic [31:0] pcpi_rd;
   logic        pcpi_wait;
   logic        pcpi_ready;

   modport master (
      output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
      input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
   );

   modport slave (
      input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
      output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
   );
endinterface

// File: rtl/pcpi_muldiv_iter.sv
// Iterative RV32M multiply/divide coprocessor for the picorv32 PCPI port.
// Multiply retires MUL_BITS_PER_CYCLE bits per cycle; divide is 1-bit/cycle restoring.
module pcpi_muldiv_iter #(
   parameter int MUL_BITS_PER_CYCLE = 1,
   parameter bit ENABLE_MUL         = 1'b1,
   parameter bit ENABLE_DIV         = 1'b1
) (
   input logic               clk,
   input logic               reset,
   pcpi_muldiv_iter_if.slave pcpi
);

   if (!(MUL_BITS_PER_CYCLE == 1 || MUL_BITS_PER_CYCLE == 2 || MUL_BITS_PER_CYCLE == 4 ||
         MUL_BITS_PER_CYCLE == 8 || MUL_BITS_PER_CYCLE == 16 || MUL_BITS_PER_CYCLE == 32)) begin : g_bad_bits
      $error("MUL_BITS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
   end

   localparam logic [4:0] MUL_LOAD = 5'(32 / MUL_BITS_PER_CYCLE - 1);
   localparam logic [4:0] DIV_LOAD = 5'd31;

   typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

   state_t      state_r;
   logic        guard_r;
   logic [4:0]  cnt_r;
   logic [2:0]  f3_r;
   logic        a_neg_r;
   logic        b_neg_r;
   logic        b_zero_r;
   logic [63:0] acc_r;
   logic [63:0] mcand_r;
   logic [31:0] mplier_r;
   logic        wait_r;
   logic        ready_r;
   logic        wr_r;
   logic [31:0] rd_r;

   logic        match_s;
   logic [2:0]  f3_s;
   logic        a_signed_s;
   logic        b_signed_s;
   logic        a_neg_s;
   logic        b_neg_s;
   logic [31:0] a_mag_s;
   logic [31:0] b_mag_s;
   logic [63:0] prod_s;
   logic [31:0] quot_s;
   logic [31:0] rem_s;
   logic [31:0] result_s;

   // Sum of the shifted multiplicand copies selected by the low multiplier bits.
   function automatic logic [63:0] mul_partial(input logic [63:0] mcand, input logic [31:0] mplier);
      logic [63:0] sum;
      sum = 64'd0;
      for (int i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
         if (mplier[i]) begin
            sum = sum + (mcand << i);
         end else begin
            sum = sum;
         end
      end
      return sum;
   endfunction

   // One restoring step on {remainder, dividend/quotient}; remainder stays below the divisor.
   function automatic logic [63:0] div_step(input logic [63:0] acc, input logic [31:0] divisor);
      logic [32:0] trial;
      logic [32:0] diff;
      trial = {acc[63:32], acc[31]};
      diff  = trial - {1'b0, divisor};
      if (!diff[32]) begin
         return {diff[31:0], acc[30:0], 1'b1};
      end else begin
         return {trial[31:0], acc[30:0], 1'b0};
      end
   endfunction

   // Instruction decode: only enabled R-type MULDIV opcodes are accepted.
   always_comb begin
      f3_s    = pcpi.pcpi_insn[14:12];
      match_s = 1'b0;
      if (pcpi.pcpi_valid && pcpi.pcpi_insn[6:0] == 7'b0110011 &&
          pcpi.pcpi_insn[31:25] == 7'b0000001) begin
         match_s = f3_s[2] ? ENABLE_DIV : ENABLE_MUL;
      end else begin
         match_s = 1'b0;
      end
   end

   // Operand signedness and magnitudes; MUL low word is sign-agnostic so it uses signed.
   always_comb begin
      a_signed_s = 1'b0;
      b_signed_s = 1'b0;
      case (f3_s)
         3'b000, 3'b001, 3'b100, 3'b110: begin
            a_signed_s = 1'b1;
            b_signed_s = 1'b1;
         end
         3'b010: begin
            a_signed_s = 1'b1;
            b_signed_s = 1'b0;
         end
         default: begin
            a_signed_s = 1'b0;
            b_signed_s = 1'b0;
         end
      endcase
      a_neg_s = a_signed_s & pcpi.pcpi_rs1[31];
      b_neg_s = b_signed_s & pcpi.pcpi_rs2[31];
      a_mag_s = a_neg_s ? (32'd0 - pcpi.pcpi_rs1) : pcpi.pcpi_rs1;
      b_mag_s = b_neg_s ? (32'd0 - pcpi.pcpi_rs2) : pcpi.pcpi_rs2;
   end

   // Sign correction and result selection; a zero divisor leaves remainder = rs1 naturally.
   always_comb begin
      prod_s   = (a_neg_r ^ b_neg_r) ? (64'd0 - acc_r) : acc_r;
      quot_s   = acc_r[31:0];
      rem_s    = a_neg_r ? (32'd0 - acc_r[63:32]) : acc_r[63:32];
      result_s = 32'd0;
      if (f3_r[2]) begin
         if (b_zero_r) begin
            quot_s = 32'hFFFF_FFFF;
         end else if (a_neg_r ^ b_neg_r) begin
            quot_s = 32'd0 - acc_r[31:0];
         end else begin
            quot_s = acc_r[31:0];
         end
         result_s = f3_r[1] ? rem_s : quot_s;
      end else begin
         result_s = (f3_r[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
      end
   end

   // Control FSM, iterative datapath and registered PCPI outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= IDLE;
         guard_r  <= 1'b0;
         cnt_r    <= 5'd0;
         f3_r     <= 3'd0;
         a_neg_r  <= 1'b0;
         b_neg_r  <= 1'b0;
         b_zero_r <= 1'b0;
         acc_r    <= 64'd0;
         mcand_r  <= 64'd0;
         mplier_r <= 32'd0;
         wait_r   <= 1'b0;
         ready_r  <= 1'b0;
         wr_r     <= 1'b0;
         rd_r     <= 32'd0;
      end else begin
         case (state_r)
            IDLE: begin
               ready_r <= 1'b0;
               wr_r    <= 1'b0;
               rd_r    <= 32'd0;
               if (guard_r) begin
                  guard_r <= 1'b0;
                  wait_r  <= 1'b0;
               end else if (match_s) begin
                  state_r  <= BUSY;
                  wait_r   <= 1'b1;
                  f3_r     <= f3_s;
                  a_neg_r  <= a_neg_s;
                  b_neg_r  <= b_neg_s;
                  b_zero_r <= (pcpi.pcpi_rs2 == 32'd0);
                  mplier_r <= b_mag_s;
                  mcand_r  <= {32'd0, a_mag_s};
                  if (f3_s[2]) begin
                     acc_r <= {32'd0, a_mag_s};
                     cnt_r <= DIV_LOAD;
                  end else begin
                     acc_r <= 64'd0;
                     cnt_r <= MUL_LOAD;
                  end
               end else begin
                  wait_r <= 1'b0;
               end
            end
            BUSY: begin
               if (!pcpi.pcpi_valid) begin
                  state_r <= IDLE;
                  wait_r  <= 1'b0;
               end else begin
                  if (f3_r[2]) begin
                     acc_r <= div_step(acc_r, mplier_r);
                  end else begin
                     acc_r    <= acc_r + mul_partial(mcand_r, mplier_r);
                     mcand_r  <= mcand_r << MUL_BITS_PER_CYCLE;
                     mplier_r <= mplier_r >> MUL_BITS_PER_CYCLE;
                  end
                  if (cnt_r == 5'd0) begin
                     state_r <= FIX;
                  end else begin
                     cnt_r <= cnt_r - 5'd1;
                  end
               end
            end
            FIX: begin
               if (!pcpi.pcpi_valid) begin
                  state_r <= IDLE;
                  wait_r  <= 1'b0;
               end else begin
                  state_r <= DONE;
                  wait_r  <= 1'b0;
                  ready_r <= 1'b1;
                  wr_r    <= 1'b1;
                  rd_r    <= result_s;
               end
            end
            DONE: begin
               state_r <= IDLE;
               guard_r <= 1'b1;
               ready_r <= 1'b0;
               wr_r    <= 1'b0;
               rd_r    <= 32'd0;
            end
            default: begin
               state_r <= IDLE;
               guard_r <= 1'b0;
               wait_r  <= 1'b0;
               ready_r <= 1'b0;
               wr_r    <= 1'b0;
               rd_r    <= 32'd0;
            end
         endcase
      end
   end

   assign pcpi.pcpi_wait  = wait_r;
   assign pcpi.pcpi_ready = ready_r;
   assign pcpi.pcpi_wr    = wr_r;
   assign pcpi.pcpi_rd    = rd_r;

endmodule

// File: tb/tb_pcpi_muldiv_iter.sv
// Self-checking bench for pcpi_muldiv_iter: four instances (1, 4, 32, 2 bits/cycle, last without DIV),
// table vectors plus random ops checked through an expected-result queue.
module tb_pcpi_muldiv_iter;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   pcpi_muldiv_iter_if if0 ();
   pcpi_muldiv_iter_if if1 ();
   pcpi_muldiv_iter_if if2 ();
   pcpi_muldiv_iter_if if3 ();

   pcpi_muldiv_iter #(.MUL_BITS_PER_CYCLE(1))  dut0 (.clk(clk), .reset(reset), .pcpi(if0));
   pcpi_muldiv_iter #(.MUL_BITS_PER_CYCLE(4))  dut1 (.clk(clk), .reset(reset), .pcpi(if1));
   pcpi_muldiv_iter #(.MUL_BITS_PER_CYCLE(32)) dut2 (.clk(clk), .reset(reset), .pcpi(if2));
   pcpi_muldiv_iter #(.MUL_BITS_PER_CYCLE(2), .ENABLE_DIV(1'b0)) dut3 (.clk(clk), .reset(reset), .pcpi(if3));

   typedef struct {
      int          d;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [31:0] rd;
      int          n;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs [18];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int kbits(input int d);
      case (d)
         0:       return 1;
         1:       return 4;
         2:       return 32;
         default: return 2;
      endcase
   endfunction

   function automatic logic [31:0] mk_insn(input logic [2:0] f3);
      return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
   endfunction

   task automatic drive(input int d, input logic v, input logic [31:0] insn, input logic [31:0] a,
                        input logic [31:0] b);
      case (d)
         0: begin if0.pcpi_valid = v; if0.pcpi_insn = insn; if0.pcpi_rs1 = a; if0.pcpi_rs2 = b; end
         1: begin if1.pcpi_valid = v; if1.pcpi_insn = insn; if1.pcpi_rs1 = a; if1.pcpi_rs2 = b; end
         2: begin if2.pcpi_valid = v; if2.pcpi_insn = insn; if2.pcpi_rs1 = a; if2.pcpi_rs2 = b; end
         default: begin if3.pcpi_valid = v; if3.pcpi_insn = insn; if3.pcpi_rs1 = a; if3.pcpi_rs2 = b; end
      endcase
   endtask

   // Returns {wr, rd, wait, ready} of the selected instance.
   function automatic logic [34:0] outs(input int d);
      case (d)
         0:       return {if0.pcpi_wr, if0.pcpi_rd, if0.pcpi_wait, if0.pcpi_ready};
         1:       return {if1.pcpi_wr, if1.pcpi_rd, if1.pcpi_wait, if1.pcpi_ready};
         2:       return {if2.pcpi_wr, if2.pcpi_rd, if2.pcpi_wait, if2.pcpi_ready};
         default: return {if3.pcpi_wr, if3.pcpi_rd, if3.pcpi_wait, if3.pcpi_ready};
      endcase
   endfunction

   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, ua, sb, ub, p;
      logic [31:0] r;
      sa = {{32{a[31]}}, a};
      ua = {32'd0, a};
      sb = {{32{b[31]}}, b};
      ub = {32'd0, b};
      r  = 32'd0;
      case (f3)
         3'd0: begin p = sa * sb; r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * ub; r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: begin
            if (b == 32'd0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else r = $signed(a) / $signed(b);
         end
         3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
            else r = $signed(a) % $signed(b);
         end
         default: r = (b == 32'd0) ? a : a % b;
      endcase
      return r;
   endfunction

   // Issue one op, follow it cycle by cycle up to the guard cycle, compare against the queue.
   task automatic run_op(input int d, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
      int          n;
      int          ready_cnt;
      bit          wait_ok;
      bit          idle_ok;
      logic [34:0] o;
      exp_t        e;
      n = f3[2] ? 32 : 32 / kbits(d);
      sb_q.push_back('{exp, n});
      @(negedge clk);
      drive(d, 1'b1, mk_insn(f3), a, b);
      @(posedge clk);
      ready_cnt = 0;
      wait_ok   = 1'b1;
      idle_ok   = 1'b1;
      for (int cyc = 1; cyc <= n + 4; cyc++) begin
         @(negedge clk);
         o = outs(d);
         if (o[1] !== (cyc <= n + 1)) wait_ok = 1'b0;
         if (o[0] === 1'b1) begin
            ready_cnt++;
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check($sformatf("rd d%0d f3=%0d", d, f3), {32'd0, o[33:2]}, {32'd0, e.rd});
               check($sformatf("wr d%0d", d), {63'd0, o[34]}, 64'd1);
               check($sformatf("latency d%0d f3=%0d", d, f3), 64'(cyc), 64'(e.n + 2));
            end else begin
               check("scoreboard_underflow", 64'd1, 64'd0);
            end
         end else if (o[34] !== 1'b0 || o[33:2] !== 32'd0) begin
            idle_ok = 1'b0;
         end
      end
      drive(d, 1'b0, 32'd0, 32'd0, 32'd0);
      check($sformatf("ready_pulses d%0d", d), 64'(ready_cnt), 64'd1);
      check($sformatf("wait_profile d%0d", d), {63'd0, wait_ok}, 64'd1);
      check($sformatf("idle_outputs d%0d", d), {63'd0, idle_ok}, 64'd1);
      if (sb_q.size() != 0) begin
         check("scoreboard_leftover", 64'(sb_q.size()), 64'd0);
         sb_q.delete();
      end
   endtask

   // Hold an instruction that must be ignored for 20 cycles.
   task automatic hold_ignored(input int d, input logic [31:0] insn, input string name);
      bit quiet;
      quiet = 1'b1;
      @(negedge clk);
      drive(d, 1'b1, insn, 32'd9, 32'd3);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (outs(d) !== 35'd0) quiet = 1'b0;
      end
      drive(d, 1'b0, 32'd0, 32'd0, 32'd0);
      check(name, {63'd0, quiet}, 64'd1);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [2:0]  rf;
      bit          quiet;
      int          d;
      n_checks = 0;
      n_fail   = 0;
      vecs[0]  = '{0, 3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
      vecs[1]  = '{1, 3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
      vecs[2]  = '{2, 3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
      vecs[3]  = '{1, 3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
      vecs[4]  = '{1, 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[5]  = '{1, 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[6]  = '{2, 3'd1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
      vecs[7]  = '{1, 3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
      vecs[8]  = '{1, 3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
      vecs[9]  = '{1, 3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF};
      vecs[10] = '{1, 3'd6, 32'd5,          32'd0,         32'd5};
      vecs[11] = '{1, 3'd5, 32'hFFFF_FFFF,  32'd0,         32'hFFFF_FFFF};
      vecs[12] = '{1, 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
      vecs[13] = '{1, 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
      vecs[14] = '{2, 3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9};
      vecs[15] = '{3, 3'd3, 32'h0001_0000,  32'h0001_0000, 32'd1};
      vecs[16] = '{2, 3'd5, 32'd100,        32'd7,         32'd14};
      vecs[17] = '{2, 3'd7, 32'd100,        32'd7,         32'd2};

      reset = 1'b0;
      for (int i = 0; i < 4; i++) drive(i, 1'b0, 32'd0, 32'd0, 32'd0);
      #12;
      for (int i = 0; i < 4; i++) check($sformatf("reset_outputs d%0d", i), {29'd0, outs(i)}, 64'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 18; i++) run_op(vecs[i].d, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);

      for (int i = 0; i < 10; i++) begin
         d  = 1 + (i % 2);
         rf = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
         run_op(d, rf, ra, rb, ref_model(rf, ra, rb));
      end

      hold_ignored(0, {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, "add_ignored");
      hold_ignored(3, mk_insn(3'd4), "div_disabled_ignored");

      // Reset in the middle of a multiply, then a clean multiply.
      @(negedge clk);
      drive(0, 1'b1, mk_insn(3'd0), 32'd3, 32'd3);
      @(posedge clk);
      repeat (5) @(posedge clk);
      #2;
      check("busy_before_reset", {63'd0, if0.pcpi_wait}, 64'd1);
      reset = 1'b0;
      drive(0, 1'b0, 32'd0, 32'd0, 32'd0);
      #1;
      check("outputs_in_reset", {29'd0, outs(0)}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      run_op(0, 3'd0, 32'd3, 32'd3, 32'd9);

      // Drop pcpi_valid mid-divide.
      @(negedge clk);
      drive(1, 1'b1, mk_insn(3'd5), 32'd100, 32'd7);
      @(posedge clk);
      repeat (3) @(negedge clk);
      check("wait_before_abort", {63'd0, if1.pcpi_wait}, 64'd1);
      drive(1, 1'b0, 32'd0, 32'd0, 32'd0);
      @(negedge clk);
      check("wait_after_abort", {63'd0, if1.pcpi_wait}, 64'd0);
      quiet = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (outs(1) !== 35'd0) quiet = 1'b0;
      end
      check("no_ready_after_abort", {63'd0, quiet}, 64'd1);
      run_op(1, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
